// File: rtl/reg_pkg.sv
// Shared defaults and types for the register-stage register file and its scoreboard.
package reg_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: reserve sets, write-back clears, reserve wins on a tie.
module rf_scoreboard
  import reg_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   RSV,
  input  logic [ADDR_W-1:0]      Addr_R,
  input  logic                   WR,
  input  logic [ADDR_W-1:0]      Addr_W,
  output logic [2**ADDR_W-1:0]   sb_next,
  output logic [2**ADDR_W-1:0]   Busy_vec,
  output logic                   Rsv_conflict
);
  localparam int DEPTH = depth(ADDR_W);

  logic rsv_ok;
  assign rsv_ok = RSV && !((ZERO_REG != 0) && (Addr_R == '0));

  always_comb begin
    sb_next = Busy_vec;
    for (int i = 0; i < DEPTH; i++) begin
      if (RSV && Addr_R == ADDR_W'(i))     sb_next[i] = 1'b1;
      else if (WR && Addr_W == ADDR_W'(i)) sb_next[i] = 1'b0;
    end
    if (ZERO_REG != 0) sb_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Busy_vec     <= '0;
      Rsv_conflict <= 1'b0;
    end else begin
      Busy_vec     <= sb_next;
      // Judged against pre-update state; a same-cycle write does not mask it.
      Rsv_conflict <= rsv_ok && Busy_vec[Addr_R];
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-first bypass and a busy scoreboard.
module reg_file_sb
  import reg_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RD_EN,
  input  logic [ADDR_W-1:0]    Addr_A,
  input  logic [ADDR_W-1:0]    Addr_B,
  input  logic                 WR,
  input  logic [ADDR_W-1:0]    Addr_W,
  input  logic [DATA_W-1:0]    Data_in,
  input  logic                 RSV,
  input  logic [ADDR_W-1:0]    Addr_R,
  output logic [DATA_W-1:0]    Src,
  output logic [DATA_W-1:0]    Dest,
  output logic                 Rd_valid,
  output logic                 Src_busy,
  output logic                 Dest_busy,
  output logic                 Rsv_conflict,
  output logic [2**ADDR_W-1:0] Busy_vec
);
  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  sb_next;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign wr_ok = WR && !((ZERO_REG != 0) && (Addr_W == '0));

  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .RSV          (RSV),
    .Addr_R       (Addr_R),
    .WR           (WR),
    .Addr_W       (Addr_W),
    .sb_next      (sb_next),
    .Busy_vec     (Busy_vec),
    .Rsv_conflict (Rsv_conflict)
  );

  always_comb begin
    rd_a = rf[Addr_A];
    rd_b = rf[Addr_B];
    if (wr_ok && Addr_W == Addr_A) rd_a = Data_in;
    if (wr_ok && Addr_W == Addr_B) rd_b = Data_in;
    if ((ZERO_REG != 0) && Addr_A == '0) rd_a = '0;
    if ((ZERO_REG != 0) && Addr_B == '0) rd_b = '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[Addr_W] <= Data_in;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Src       <= '0;
      Dest      <= '0;
      Rd_valid  <= 1'b0;
      Src_busy  <= 1'b0;
      Dest_busy <= 1'b0;
    end else begin
      Rd_valid <= RD_EN;
      if (RD_EN) begin
        Src       <= rd_a;
        Dest      <= rd_b;
        // Post-update busy view so issue logic sees this cycle's reserve/write-back.
        Src_busy  <= sb_next[Addr_A];
        Dest_busy <= sb_next[Addr_B];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Random + directed bench for reg_file_sb against a behavioural model, both ZERO_REG settings.
module tb_reg_file_sb;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic        RD_EN, WR, RSV;
  logic [2:0]  Addr_A, Addr_B, Addr_W, Addr_R;
  logic [15:0] Data_in;

  logic [15:0] src0, dst0, srcz, dstz;
  logic        rv0, sbs0, dbs0, cf0, rvz, sbsz, dbsz, cfz;
  logic [7:0]  bv0, bvz;

  int checks = 0;
  int errors = 0;

  // model: index 0 = ZERO_REG=0 instance, 1 = ZERO_REG=1 instance
  logic [15:0] mm [2][8];
  logic [7:0]  ms [2];
  logic [15:0] e_src [2], e_dst [2];
  logic        e_rv [2], e_sbs [2], e_dbs [2], e_cf [2];

  always #5 CLK = ~CLK;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut (
    .CLK(CLK), .RSTn(RSTn), .RD_EN(RD_EN), .Addr_A(Addr_A), .Addr_B(Addr_B),
    .WR(WR), .Addr_W(Addr_W), .Data_in(Data_in), .RSV(RSV), .Addr_R(Addr_R),
    .Src(src0), .Dest(dst0), .Rd_valid(rv0), .Src_busy(sbs0), .Dest_busy(dbs0),
    .Rsv_conflict(cf0), .Busy_vec(bv0));

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dutz (
    .CLK(CLK), .RSTn(RSTn), .RD_EN(RD_EN), .Addr_A(Addr_A), .Addr_B(Addr_B),
    .WR(WR), .Addr_W(Addr_W), .Data_in(Data_in), .RSV(RSV), .Addr_R(Addr_R),
    .Src(srcz), .Dest(dstz), .Rd_valid(rvz), .Src_busy(sbsz), .Dest_busy(dbsz),
    .Rsv_conflict(cfz), .Busy_vec(bvz));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) mm[k][r] = '0;
      ms[k] = '0;
      e_src[k] = '0; e_dst[k] = '0;
      e_rv[k] = 1'b0; e_sbs[k] = 1'b0; e_dbs[k] = 1'b0; e_cf[k] = 1'b0;
    end
  endtask

  // One rising edge worth of architectural effect, from the stated rules.
  task automatic model_step();
    logic        zr, wok, rok;
    logic [15:0] ra, rb;
    logic [7:0]  nsb;
    for (int k = 0; k < 2; k++) begin
      zr  = (k == 1);
      wok = WR  && !(zr && Addr_W == 3'd0);
      rok = RSV && !(zr && Addr_R == 3'd0);
      ra  = (zr && Addr_A == 3'd0) ? 16'h0 : (wok && Addr_W == Addr_A) ? Data_in : mm[k][Addr_A];
      rb  = (zr && Addr_B == 3'd0) ? 16'h0 : (wok && Addr_W == Addr_B) ? Data_in : mm[k][Addr_B];
      nsb = ms[k];
      if (wok) nsb[Addr_W] = 1'b0;
      if (rok) nsb[Addr_R] = 1'b1;
      e_cf[k] = rok && ms[k][Addr_R];
      if (wok) mm[k][Addr_W] = Data_in;
      e_rv[k] = RD_EN;
      if (RD_EN) begin
        e_src[k] = ra; e_dst[k] = rb;
        e_sbs[k] = nsb[Addr_A]; e_dbs[k] = nsb[Addr_B];
      end
      ms[k] = nsb;
    end
  endtask

  task automatic compare_all();
    chk("src",    32'(src0), 32'(e_src[0]));  chk("dest",   32'(dst0), 32'(e_dst[0]));
    chk("rdv",    32'(rv0),  32'(e_rv[0]));   chk("sbusy",  32'(sbs0), 32'(e_sbs[0]));
    chk("dbusy",  32'(dbs0), 32'(e_dbs[0]));  chk("cfl",    32'(cf0),  32'(e_cf[0]));
    chk("bvec",   32'(bv0),  32'(ms[0]));
    chk("z_src",  32'(srcz), 32'(e_src[1]));  chk("z_dest", 32'(dstz), 32'(e_dst[1]));
    chk("z_rdv",  32'(rvz),  32'(e_rv[1]));   chk("z_sbusy",32'(sbsz), 32'(e_sbs[1]));
    chk("z_dbusy",32'(dbsz), 32'(e_dbs[1]));  chk("z_cfl",  32'(cfz),  32'(e_cf[1]));
    chk("z_bvec", 32'(bvz),  32'(ms[1]));
  endtask

  task automatic idle();
    RD_EN = 0; WR = 0; RSV = 0;
    Addr_A = 0; Addr_B = 0; Addr_W = 0; Addr_R = 0; Data_in = 0;
  endtask

  // Inputs are set at the falling edge; model advances at the rising edge; compare at the next fall.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
    idle();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_src"},  32'(src0), 0); chk({tag, "_dest"}, 32'(dst0), 0);
    chk({tag, "_rdv"},  32'(rv0),  0); chk({tag, "_sb"},   32'(sbs0), 0);
    chk({tag, "_db"},   32'(dbs0), 0); chk({tag, "_cf"},   32'(cf0),  0);
    chk({tag, "_bv"},   32'(bv0),  0); chk({tag, "_zbv"},  32'(bvz),  0);
    chk({tag, "_zsrc"}, 32'(srcz), 0);
  endtask

  initial begin
    RSTn = 1'b0;
    idle();
    model_reset();
    #3;
    all_zero("por");
    @(negedge CLK); @(negedge CLK);
    RSTn = 1'b1;

    // 1: fill, reserve, async reset between edges
    for (int r = 1; r < 8; r++) begin
      WR = 1; Addr_W = 3'(r); Data_in = 16'(r * 16'h1111);
      tick();
    end
    RSV = 1; Addr_R = 3'd3; RD_EN = 1; Addr_A = 3'd7; Addr_B = 3'd3;
    tick();
    chk("p1_pre_bv", 32'(bv0), 32'h08);
    chk("p1_pre_src", 32'(src0), 32'h7777);
    #2 RSTn = 1'b0;
    #1 all_zero("p1_rst");
    model_reset();
    @(negedge CLK);
    all_zero("p1_hold");
    RSTn = 1'b1;
    RD_EN = 1; Addr_A = 3'd3;
    tick();
    chk("p1_src", 32'(src0), 0); chk("p1_sb", 32'(sbs0), 0); chk("p1_bv", 32'(bv0), 0);

    // 2: basic write then read
    WR = 1; Addr_W = 3'd5; Data_in = 16'hBEEF;
    tick();
    RD_EN = 1; Addr_A = 3'd5; Addr_B = 3'd2;
    tick();
    chk("p2_src", 32'(src0), 32'hBEEF); chk("p2_dest", 32'(dst0), 0); chk("p2_rdv", 32'(rv0), 1);
    tick();
    chk("p2_rdv_off", 32'(rv0), 0); chk("p2_src_hold", 32'(src0), 32'hBEEF);

    // 3: bypass on both ports
    WR = 1; Addr_W = 3'd4; Data_in = 16'h1234; RD_EN = 1; Addr_A = 3'd4; Addr_B = 3'd4;
    tick();
    chk("p3_src", 32'(src0), 32'h1234); chk("p3_dest", 32'(dst0), 32'h1234);
    RD_EN = 1; Addr_A = 3'd4; Addr_B = 3'd5;
    tick();
    chk("p3_store", 32'(src0), 32'h1234); chk("p3_destB", 32'(dst0), 32'hBEEF);

    // 4: reserve, observe busy, write-back clears
    RSV = 1; Addr_R = 3'd6;
    tick();
    RD_EN = 1; Addr_A = 3'd6;
    tick();
    chk("p4_sb", 32'(sbs0), 1); chk("p4_bv", 32'(bv0), 32'h40);
    WR = 1; Addr_W = 3'd6; Data_in = 16'h00AA; RD_EN = 1; Addr_A = 3'd6;
    tick();
    chk("p4_src", 32'(src0), 32'h00AA); chk("p4_sb_clr", 32'(sbs0), 0); chk("p4_bv_clr", 32'(bv0), 0);

    // 5: reserve beats same-cycle write, conflict flagged
    RSV = 1; Addr_R = 3'd2;
    tick();
    chk("p5_cf0", 32'(cf0), 0);
    RSV = 1; Addr_R = 3'd2; WR = 1; Addr_W = 3'd2; Data_in = 16'h5555;
    tick();
    chk("p5_cf", 32'(cf0), 1); chk("p5_bv2", 32'(bv0[2]), 1);
    RD_EN = 1; Addr_A = 3'd2;
    tick();
    chk("p5_cf_off", 32'(cf0), 0); chk("p5_src", 32'(src0), 32'h5555); chk("p5_bv2b", 32'(bv0[2]), 1);

    // 6: register zero on the ZERO_REG=1 instance
    WR = 1; Addr_W = 3'd0; Data_in = 16'hFFFF;
    tick();
    RSV = 1; Addr_R = 3'd0;
    tick();
    chk("p6_bv0a", 32'(bvz[0]), 0); chk("p6_cfa", 32'(cfz), 0);
    RSV = 1; Addr_R = 3'd0; RD_EN = 1; Addr_A = 3'd0;
    tick();
    chk("p6_src", 32'(srcz), 0); chk("p6_sb", 32'(sbsz), 0);
    chk("p6_cf", 32'(cfz), 0); chk("p6_bv0", 32'(bvz[0]), 0);
    chk("p6_nz_cf", 32'(cf0), 1); chk("p6_nz_src", 32'(src0), 32'hFFFF);

    // random mix, with occasional mid-cycle reset
    for (int n = 0; n < 3000; n++) begin
      RD_EN = 1'($urandom_range(0, 1));
      WR    = 1'($urandom_range(0, 1));
      RSV   = ($urandom_range(0, 2) == 0);
      Addr_A = 3'($urandom); Addr_B = 3'($urandom);
      Addr_W = 3'($urandom); Addr_R = 3'($urandom);
      Data_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) Addr_A = Addr_W;
      if ($urandom_range(0, 3) == 0) Addr_R = Addr_W;
      if ($urandom_range(0, 499) == 0) begin
        #2 RSTn = 1'b0;
        #1 all_zero("rnd_rst");
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;
        idle();
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
